// File: rtl/jpeg_quantizer_pkg.sv
// Shared types and constants for the JPEG quantiser: table precision, block geometry
// and the luma/chroma table selector.
package jpeg_quantizer_pkg;

  localparam int QUAN_RECIP_BITWIDTH = 16;
  localparam int MCU_EDGE            = 8;
  localparam int MCU_COEFFS          = MCU_EDGE * MCU_EDGE;

  typedef logic [$clog2(MCU_COEFFS)-1:0] coef_idx_t;

  typedef enum logic {
    TBL_LUMA   = 1'b0,
    TBL_CHROMA = 1'b1
  } tbl_sel_e;

endpackage

// File: rtl/jpeg_quant_recip_tbl.sv
// Luma and chroma reciprocal tables: one shared write port, two asynchronous read ports
// on the same index. A write lands at the clock edge, so a same-cycle read sees the old value.
module jpeg_quant_recip_tbl
  import jpeg_quantizer_pkg::*;
#(
  parameter int DEPTH = MCU_COEFFS,
  parameter int W     = QUAN_RECIP_BITWIDTH + 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  tbl_sel_e      i_sel,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_luma,
  output logic [W-1:0]  o_chroma
);

  logic [W-1:0] r_luma   [DEPTH];
  logic [W-1:0] r_chroma [DEPTH];

  // Contents deliberately survive reset so tables are loaded once per stream setup.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_sel == TBL_CHROMA) r_chroma[i_waddr] <= i_wdata;
      else                     r_luma[i_waddr]   <= i_wdata;
    end
  end

  assign o_luma   = r_luma[i_raddr];
  assign o_chroma = r_chroma[i_raddr];

endmodule

// File: rtl/jpeg_quantizer.sv
// Three-stage quantiser: table lookup, reciprocal multiply, round-half-away-from-zero
// and saturate. The whole pipe stalls together on downstream backpressure.
module jpeg_quantizer
  import jpeg_quantizer_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int DCT_W    = 16,
  parameter int QUAN_W   = 12,
  parameter int MCU_SIZE = MCU_EDGE,
  parameter int RECIP_W  = QUAN_RECIP_BITWIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [NUM_CH*DCT_W-1:0]                s_data,
  input  logic                                   s_last,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [NUM_CH*QUAN_W-1:0]               m_data,
  output logic                                   m_last,
  input  logic                                   tbl_we,
  input  logic                                   tbl_sel,
  input  logic [$clog2(MCU_SIZE*MCU_SIZE)-1:0]   tbl_addr,
  input  logic [RECIP_W:0]                       tbl_data,
  output logic                                   err_last
);

  localparam int COEFFS = MCU_SIZE * MCU_SIZE;
  localparam int IDX_W  = $clog2(COEFFS);
  localparam int TW     = RECIP_W + 1;
  localparam int PW     = DCT_W + TW;
  localparam int QB     = PW - RECIP_W + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(COEFFS - 1);
  localparam logic [PW:0]       HALF     = (PW+1)'(1) << (RECIP_W - 1);
  localparam logic [QB-1:0]     QPOS     = QB'((1 << (QUAN_W - 1)) - 1);
  localparam logic [QB-1:0]     QNEG     = QB'(1 << (QUAN_W - 1));
  localparam logic [QUAN_W-1:0] SAT_POS  = {1'b0, {(QUAN_W-1){1'b1}}};
  localparam logic [QUAN_W-1:0] SAT_NEG  = {1'b1, {(QUAN_W-1){1'b0}}};

  logic [3:1]                     r_vld_pipe;
  logic                           w_adv, w_acc;
  logic [IDX_W-1:0]               r_idx, w_idx_nxt;
  logic                           r_err;
  logic [NUM_CH-1:0][DCT_W-1:0]   w_coef, r1_coef;
  logic [TW-1:0]                  w_rl, w_rc, r1_rl, r1_rc;
  logic                           r1_last, r2_last, r_mlast;
  logic [NUM_CH-1:0][PW-1:0]      w_prod, r2_prod;
  logic [NUM_CH-1:0][QUAN_W-1:0]  w_quant, r_mdata;

  assign w_adv     = !r_vld_pipe[3] || m_ready;
  assign w_acc     = s_valid && w_adv;
  assign s_ready   = w_adv;
  assign w_coef    = s_data;
  // s_last always restarts the block so a lost/extra beat cannot skew later blocks.
  assign w_idx_nxt = (s_last || r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);

  jpeg_quant_recip_tbl #(.DEPTH(COEFFS), .W(TW)) u_tbl (
    .clk      (clk),
    .i_we     (tbl_we),
    .i_sel    (tbl_sel_e'(tbl_sel)),
    .i_waddr  (tbl_addr),
    .i_wdata  (tbl_data),
    .i_raddr  (r_idx),
    .o_luma   (w_rl),
    .o_chroma (w_rc)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [TW-1:0]        w_recip;
    logic signed [PW-1:0] w_a, w_b;
    logic                 w_neg;
    logic [PW-1:0]        w_mag;
    logic [PW:0]          w_sum;
    logic [QB-1:0]        w_q;
    logic [QUAN_W-1:0]    w_sat;

    assign w_recip   = (c == 0) ? r1_rl : r1_rc;
    assign w_a       = PW'($signed(r1_coef[c]));
    assign w_b       = PW'({1'b0, w_recip});
    assign w_prod[c] = w_a * w_b;

    // Round on magnitude so halves go away from zero symmetrically.
    assign w_neg = r2_prod[c][PW-1];
    assign w_mag = w_neg ? (PW'(0) - r2_prod[c]) : r2_prod[c];
    assign w_sum = {1'b0, w_mag} + HALF;
    assign w_q   = QB'(w_sum >> RECIP_W);

    always_comb begin
      if (!w_neg) w_sat = (w_q > QPOS) ? SAT_POS : QUAN_W'(w_q);
      else        w_sat = (w_q > QNEG) ? SAT_NEG : QUAN_W'(QB'(0) - w_q);
    end

    assign w_quant[c] = w_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r1_last    <= 1'b0;
      r2_last    <= 1'b0;
      r_mdata    <= '0;
      r_mlast    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_idx <= w_idx_nxt;
        if (s_last != (r_idx == LAST_IDX)) r_err <= 1'b1;
      end
      if (w_adv) begin
        r_vld_pipe <= {r_vld_pipe[2:1], s_valid};
        r1_last    <= s_valid & s_last;
        r2_last    <= r1_last;
        r_mdata    <= w_quant;
        r_mlast    <= r2_last;
      end
    end
  end

  // Datapath carries no reset; validity is tracked by r_vld_pipe alone.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_coef <= w_coef;
      r1_rl   <= w_rl;
      r1_rc   <= w_rc;
      r2_prod <= w_prod;
    end
  end

  assign m_valid  = r_vld_pipe[3];
  assign m_data   = r_mdata;
  assign m_last   = r_mlast;
  assign err_last = r_err;

endmodule

// File: tb/tb_jpeg_quantizer.sv
// Scoreboard bench for jpeg_quantizer: stimulus pushes expected beats, a negedge monitor
// pops and compares every accepted output beat.
module tb_jpeg_quantizer;

  localparam int NC = 3;
  localparam int DW = 16;
  localparam int QW = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [NC*DW-1:0]  s_data = '0;
  logic              m_valid, m_ready = 1'b1, m_last;
  logic [NC*QW-1:0]  m_data;
  logic              tbl_we = 1'b0, tbl_sel = 1'b0;
  logic [5:0]        tbl_addr = '0;
  logic [16:0]       tbl_data = '0;
  logic              err_last;

  typedef struct {
    logic [NC*QW-1:0] data;
    logic             last;
  } exp_t;

  exp_t q[$];
  int   pop_cyc[$];
  int   checks = 0, errors = 0, cyc = 0, midx = 0;
  int   tl[64], tc[64];

  always #5 clk = ~clk;

  jpeg_quantizer dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .err_last(err_last)
  );

  always @(posedge clk) cyc++;

  // Monitor: a beat transfers at the next posedge when m_valid && m_ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_valid && m_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected act=%h last=%b exp=none", m_data, m_last);
      end else begin
        e = q.pop_front();
        if (m_data !== e.data || m_last !== e.last) begin
          errors++;
          $display("FAIL out_beat act=%h last=%b exp=%h last=%b", m_data, m_last, e.data, e.last);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int mq(input int coef, input int r);
    longint p, m, v;
    p = longint'(coef) * longint'(r);
    m = (p < 0) ? -p : p;
    v = (m + 32768) / 65536;
    if (p < 0) v = -v;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return int'(v);
  endfunction

  function automatic logic [35:0] pk(input int a, input int b, input int c);
    logic [11:0] x, y, z;
    x = a[11:0]; y = b[11:0]; z = c[11:0];
    return {z, y, x};
  endfunction

  function automatic logic [47:0] dv(input int a, input int b, input int c);
    logic [15:0] x, y, z;
    x = a[15:0]; y = b[15:0]; z = c[15:0];
    return {z, y, x};
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Holds s_valid until accepted; leaves it asserted so callers can stream back-to-back.
  task automatic send(input logic [47:0] d, input bit last, input logic [35:0] e);
    bit ok = 0;
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!ok && n < 200) begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); n++;
    end
    #1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout act=not_ready exp=accepted");
    end else begin
      q.push_back('{e, last});
      midx = (last || midx == 63) ? 0 : midx + 1;
    end
  endtask

  task automatic send_m(input int c0, input int c1, input int c2, input bit last);
    logic [35:0] e;
    e = pk(mq(c0, tl[midx]), mq(c1, tc[midx]), mq(c2, tc[midx]));
    send(dv(c0, c1, c2), last, e);
  endtask

  task automatic idle();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic twr(input bit sel, input int a, input int v);
    tbl_we = 1'b1; tbl_sel = sel; tbl_addr = a[5:0]; tbl_data = v[16:0];
    @(posedge clk); #1;
    tbl_we = 1'b0;
    if (sel) tc[a] = v; else tl[a] = v;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_err_last", 64'(err_last), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      twr(1'b0, i, 4096);
      twr(1'b1, i, 8192);
    end
    twr(1'b1, 5, 65536);
    twr(1'b1, 6, 65536);

    // Directed block: hand-computed values, then latency of the first beat.
    send(dv(100, 0, 0), 1'b0, pk(6, 0, 0));
    idle();
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!m_valid && n < 10);
    chk("latency", 64'(n), 64'd3);
    @(posedge clk); #1;
    send(dv(-100, 0, 0), 1'b0, pk(-6, 0, 0));
    send(dv(8, 0, 0), 1'b0, pk(1, 0, 0));
    send(dv(-8, 0, 0), 1'b0, pk(-1, 0, 0));
    send(dv(0, 0, 0), 1'b0, pk(0, 0, 0));
    send(dv(0, 32767, 0), 1'b0, pk(0, 2047, 0));
    send(dv(0, -32768, 0), 1'b0, pk(0, -2048, 0));
    for (int i = 7; i < 64; i++) send_m(rnd(), rnd(), rnd(), i == 63);
    idle();
    drain();
    chk("blk1_err_last", 64'(err_last), 64'd0);

    // Back-to-back block: outputs must land on 64 consecutive cycles.
    base = pop_cyc.size();
    for (int i = 0; i < 64; i++) send_m(rnd(), rnd(), rnd(), i == 63);
    idle();
    drain();
    chk("blk2_consecutive",
        64'((pop_cyc.size() >= base + 64) ? pop_cyc[base+63] - pop_cyc[base] : -1), 64'd63);
    chk("blk2_err_last", 64'(err_last), 64'd0);

    // Backpressure: m_ready low 10 cycles mid-block.
    fork
      begin
        for (int i = 0; i < 64; i++) send_m(rnd(), rnd(), rnd(), i == 63);
        idle();
      end
      begin
        repeat (20) @(posedge clk);
        #1 m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (i == 5) begin
            chk("stall_s_ready", 64'(s_ready), 64'd0);
            chk("stall_inflight", 64'(q.size()), 64'd3);
            if (q.size() > 0) chk("stall_held_data", 64'(m_data), 64'(q[0].data));
          end
          @(posedge clk);
        end
        #1 m_ready = 1'b1;
      end
    join
    drain();
    chk("blk3_err_last", 64'(err_last), 64'd0);

    // Early s_last at beat 40 flags an error and resyncs the index to 0.
    twr(1'b0, 0, 65536);
    for (int i = 0; i <= 40; i++) send_m(rnd(), rnd(), rnd(), i == 40);
    send(dv(100, 0, 0), 1'b0, pk(100, 0, 0));
    idle();
    drain();
    chk("early_last_err", 64'(err_last), 64'd1);
    for (int i = 0; i < 3; i++) send_m(rnd(), rnd(), rnd(), 1'b0);
    idle();
    drain();
    chk("err_sticky", 64'(err_last), 64'd1);

    // Reset with three beats in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_m(rnd(), rnd(), rnd(), 1'b0);
    idle();
    rst = 1'b1;
    q.delete();
    midx = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_last", 64'(m_last), 64'd0);
    chk("midrst_err_last", 64'(err_last), 64'd0);
    m_ready = 1'b1;
    send(dv(100, 0, 0), 1'b0, pk(100, 0, 0));
    for (int i = 1; i < 5; i++) send(dv(0, 0, 0), 1'b0, pk(0, 0, 0));
    send(dv(0, 32767, 0), 1'b0, pk(0, 2047, 0));
    idle();
    drain();
    chk("post_rst_err_last", 64'(err_last), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
